// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad responder: queues key requests and presses each one on the Row/Col matrix.
// Optional contact bounce at press and release is built when HEX_KEYPAD_EMU_BOUNCE_EN is defined.
module hex_keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [3:0]                    key_code,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic [3:0]                    Col,
  output logic [3:0]                    Row,
  output logic                          S_Row,
  output logic                          busy,
  output logic                          press_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned MaxHg    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc   = (MaxHg > BOUNCE_CYCLES) ? MaxHg : BOUNCE_CYCLES;
  localparam int unsigned CW       = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StGap
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
    , StBounceIn,
    StBounceOut
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          contact_q, contact_d;
  logic          done_q, done_d;
  logic [3:0]    active_q;
  logic          sync1_q, s_row_q;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign key_ready  = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push       = key_valid && key_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign press_done = done_q;
  assign S_Row      = s_row_q;

  // Combinational in Col so a scanner strobe sees its row return in the same cycle.
  assign Row = (contact_q && Col[active_q[1:0]]) ? (4'b0001 << active_q[3:2]) : 4'b0000;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      active_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= key_code;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        active_q <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // State register; contact and done are registered from the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
        if (pop) state_d = StBounceIn;
`else
        if (pop) state_d = StHold;
`endif
      end
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
      StBounceIn: if (cnt_q == CW'(BOUNCE_CYCLES - 1)) begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StBounceOut: if (cnt_q == CW'(BOUNCE_CYCLES - 1)) begin
        state_d = StGap;
        cnt_d   = '0;
      end
`endif
      StHold: if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
        state_d = StBounceOut;
`else
        state_d = StGap;
`endif
        cnt_d   = '0;
      end
      StGap: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    contact_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      StHold: contact_d = 1'b1;
      StGap:  done_d    = (cnt_q == CW'(GAP_CYCLES - 1));
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
      StBounceIn:  contact_d = ~cnt_q[0];
      StBounceOut: contact_d = cnt_q[0];
`endif
      default: contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_row_q <= 1'b0;
    end else begin
      sync1_q <= |Row;
      s_row_q <= sync1_q;
    end
  end

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Self-checking bench for hex_keypad_emulator against a press-timeline reference model.
// Honours HEX_KEYPAD_EMU_BOUNCE_EN for expected press timing.
module tb_hex_keypad_emulator;

  localparam int H = 64;
  localparam int G = 16;
  localparam int B = 8;
  localparam int D = 4;
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
  localparam int LEN = 2 * B + H + G;
  localparam int ONES = H + B;
`else
  localparam int LEN = H + G;
  localparam int ONES = H;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       S_Row;
  logic       busy;
  logic       press_done;
  logic [2:0] fifo_count;

  hex_keypad_emulator #(
    .HOLD_CYCLES  (H),
    .GAP_CYCLES   (G),
    .BOUNCE_CYCLES(B),
    .FIFO_DEPTH   (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .Col       (Col),
    .Row       (Row),
    .S_Row     (S_Row),
    .busy      (busy),
    .press_done(press_done),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: m_k counts edges since the pop of the active key (-1 when idle).
  logic [3:0] m_q[$];
  int         m_k;
  logic [3:0] m_act;
  logic       m_sync1, m_srow;
  logic [3:0] m_row;
  logic       m_busy, m_done, m_ready;
  logic [2:0] m_count;

  function automatic logic m_contact(int k);
    if (k < 1) return 1'b0;
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
    if (k <= B) return ((k - 1) % 2) == 0;
    if (k <= B + H) return 1'b1;
    if (k <= 2 * B + H) return ((k - B - H - 1) % 2) == 1;
    return 1'b0;
`else
    return k <= H;
`endif
  endfunction

  function automatic logic [3:0] m_row_for(logic [3:0] col);
    logic [1:0] ci;
    ci = m_act[1:0];
    if (m_contact(m_k) && col[ci]) return 4'b0001 << m_act[3:2];
    return 4'b0000;
  endfunction

  function automatic logic m_idle();
    return (m_k < 0) || (m_k == LEN);
  endfunction

  task automatic m_update();
    m_row   = m_row_for(Col);
    m_busy  = !m_idle() || (m_q.size() > 0);
    m_done  = (m_k == LEN);
    m_ready = (m_q.size() < D);
    m_count = 3'(m_q.size());
  endtask

  task automatic m_reset();
    m_q.delete();
    m_k     = -1;
    m_act   = 4'h0;
    m_sync1 = 1'b0;
    m_srow  = 1'b0;
    m_update();
  endtask

  task automatic tick(input logic v, input logic [3:0] code, input logic [3:0] col);
    logic or_pre, idle_pre, do_push;
    int   size;
    key_valid = v;
    key_code  = code;
    Col       = col;
    or_pre    = |m_row_for(col);
    size      = m_q.size();
    idle_pre  = m_idle();
    do_push   = v && (size < D);
    @(posedge clock);
    if (idle_pre && size > 0) begin
      m_act = m_q.pop_front();
      m_k   = 0;
    end else if (m_k >= 0 && m_k < LEN) begin
      m_k++;
    end else begin
      m_k = -1;
    end
    if (do_push) m_q.push_back(code);
    m_srow  = m_sync1;
    m_sync1 = or_pre;
    #1;
    m_update();
  endtask

  task automatic drain(input logic [3:0] col);
    int n = 0;
    while (!(m_idle() && m_q.size() == 0) && n < 3000) begin
      tick(1'b0, 4'h0, col);
      n++;
    end
    n_checks++;
    if (n >= 3000) $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    Col = 4'hF;
    repeat (3) @(posedge clock);
    #1;
    m_reset();
    n_checks++;
    if ({Row, S_Row, key_ready, busy, press_done, fifo_count} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_values: Row=%b S_Row=%b ready=%b busy=%b done=%b count=%0d, required 0000 0 1 0 0 0",
               Row, S_Row, key_ready, busy, press_done, fifo_count);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_empty_push();
    tick(1'b1, 4'h5, 4'hF);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL empty_push_busy: busy=%b, required 1", busy);
    else n_pass++;
    tick(1'b0, 4'h0, 4'hF);
    n_checks++;
    if (Row !== 4'b0000) $display("FAIL empty_push_pop_row: Row=%b, required 0000", Row);
    else n_pass++;
    tick(1'b0, 4'h0, 4'hF);
    n_checks++;
    if (Row !== 4'b0010) $display("FAIL empty_push_contact: Row=%b, required 0010", Row);
    else n_pass++;
    drain(4'hF);
  endtask

  task automatic test_single_press();
    int ones = 0, row_rise = -1, srow_rise = -1, row_fall = -1, srow_fall = -1, done_at = -1;
    int errs = 0;
    tick(1'b1, 4'h6, 4'b0100);
    for (int c = 0; c < LEN + 6; c++) begin
      tick(1'b0, 4'h0, 4'b0100);
      if (Row !== m_row || S_Row !== m_srow || press_done !== m_done) begin
        errs++;
        if (errs < 4)
          $display("FAIL single_press_cycle%0d: Row=%b S_Row=%b done=%b, required %b %b %b",
                   c, Row, S_Row, press_done, m_row, m_srow, m_done);
      end
      if (Row === 4'b0010) ones++;
      if (Row === 4'b0010 && row_rise < 0) row_rise = c;
      if (S_Row === 1'b1 && srow_rise < 0) srow_rise = c;
      if (Row === 4'b0010) row_fall = c + 1;
      if (S_Row === 1'b1) srow_fall = c + 1;
      if (press_done === 1'b1 && done_at < 0) done_at = c;
    end
    n_checks++;
    if (errs != 0) $display("FAIL single_press_model: %0d cycles differ, required 0", errs);
    else n_pass++;
    n_checks++;
    if (ones != ONES) $display("FAIL single_press_hold: Row=0010 for %0d cycles, required %0d", ones, ONES);
    else n_pass++;
    n_checks++;
    if (srow_rise - row_rise != 2 || srow_fall - row_fall != 2)
      $display("FAIL single_press_srow_lag: rise lag %0d fall lag %0d, required 2 2",
               srow_rise - row_rise, srow_fall - row_fall);
    else n_pass++;
    // Pop is on the first tick of the loop (c=0); done follows LEN edges later.
    n_checks++;
    if (done_at != LEN) $display("FAIL single_press_done_time: %0d edges after pop, required %0d", done_at, LEN);
    else n_pass++;
    drain(4'b0100);
  endtask

  task automatic test_col_patterns();
    logic [3:0] codes[3]   = '{4'h6, 4'hF, 4'h0};
    logic [3:0] cols[5]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
    logic [3:0] exp6[5]    = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    logic [3:0] single[3]  = '{4'b0000, 4'b1000, 4'b0001};
    logic [3:0] single_r[3] = '{4'b0000, 4'b1000, 4'b0001};
    int errs = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, codes[i], 4'h0);
      while (m_k < B + 4) tick(1'b0, 4'h0, 4'h0);
      if (i == 0) begin
        for (int j = 0; j < 5; j++) begin
          tick(1'b0, 4'h0, cols[j]);
          n_checks++;
          if (Row !== exp6[j]) $display("FAIL col_step_6_%b: Row=%b, required %b", cols[j], Row, exp6[j]);
          else n_pass++;
        end
      end else begin
        tick(1'b0, 4'h0, single[i]);
        n_checks++;
        if (Row !== single_r[i])
          $display("FAIL col_single_%h: Row=%b, required %b", codes[i], Row, single_r[i]);
        else n_pass++;
      end
      for (int j = 0; j < 20; j++) begin
        tick(1'b0, 4'h0, 4'($urandom));
        if (Row !== m_row) errs++;
      end
      drain(4'h0);
    end
    n_checks++;
    if (errs != 0) $display("FAIL col_random: %0d Row values differ, required 0", errs);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes[5] = '{4'h1, 4'h4, 4'h9, 4'hA, 4'hC};
    logic [7:0] obs[$];
    logic [3:0] racc, cacc, c;
    int max_cnt = 0, wait5 = 0, errs = 0, guard = 0, cyc = 0;
    logic acc;
    tick(1'b1, 4'h0, 4'hF);
    tick(1'b0, 4'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      acc = 1'b0;
      while (!acc && guard < 500) begin
        acc = m_q.size() < D;
        tick(1'b1, codes[i], 4'hF);
        if (key_ready !== m_ready || fifo_count !== m_count) errs++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (i == 4) wait5++;
        guard++;
      end
    end
    key_valid = 1'b0;
    n_checks++;
    if (errs != 0) $display("FAIL b2b_ready_count: %0d cycles differ from model, required 0", errs);
    else n_pass++;
    n_checks++;
    if (max_cnt != D) $display("FAIL b2b_full: max fifo_count=%0d, required %0d", max_cnt, D);
    else n_pass++;
    n_checks++;
    if (wait5 < 2) $display("FAIL b2b_fifth_wait: accepted after %0d tries, required >=2", wait5);
    else n_pass++;
    racc = 4'h0;
    cacc = 4'h0;
    errs = 0;
    while (!(m_idle() && m_q.size() == 0) && cyc < 3000) begin
      tick(1'b0, 4'h0, 4'b0001 << (cyc % 4));
      if (Row !== m_row || busy !== m_busy) errs++;
      if (Row !== 4'h0) begin
        racc |= Row;
        cacc |= Col;
      end
      if (press_done === 1'b1) begin
        obs.push_back({racc, cacc});
        racc = 4'h0;
        cacc = 4'h0;
      end
      cyc++;
    end
    n_checks++;
    if (errs != 0 || cyc >= 3000) $display("FAIL b2b_drain: %0d cycles differ, %0d cycles used", errs, cyc);
    else n_pass++;
    n_checks++;
    if (obs.size() != 5) $display("FAIL b2b_press_count: %0d presses, required 5", obs.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      c = codes[i];
      n_checks++;
      if (obs[i] !== {4'b0001 << c[3:2], 4'b0001 << c[1:0]})
        $display("FAIL b2b_order_%0d: row/col=%h, required %h", i, obs[i],
                 {4'b0001 << c[3:2], 4'b0001 << c[1:0]});
      else n_pass++;
    end
  endtask

`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
  task automatic test_bounce();
    logic exp_seq[$];
    int errs = 0;
    for (int i = 0; i < B; i++) exp_seq.push_back(i % 2 == 0);
    for (int i = 0; i < H; i++) exp_seq.push_back(1'b1);
    for (int i = 0; i < B; i++) exp_seq.push_back(i % 2 == 1);
    for (int i = 0; i < G; i++) exp_seq.push_back(1'b0);
    tick(1'b1, 4'h3, 4'hF);
    tick(1'b0, 4'h0, 4'hF);
    for (int i = 0; i < exp_seq.size(); i++) begin
      tick(1'b0, 4'h0, 4'hF);
      if (Row[0] !== exp_seq[i]) begin
        errs++;
        if (errs < 4) $display("FAIL bounce_cycle%0d: Row[0]=%b, required %b", i, Row[0], exp_seq[i]);
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL bounce_sequence: %0d cycles differ, required 0", errs);
    else n_pass++;
    drain(4'hF);
  endtask
`endif

  task automatic test_reset_mid();
    int done_seen = 0;
    tick(1'b1, 4'hB, 4'hF);
    tick(1'b1, 4'h2, 4'hF);
    tick(1'b1, 4'h7, 4'hF);
    while (m_k < B + 10) tick(1'b0, 4'h0, 4'hF);
    n_checks++;
    if (Row !== m_row || Row === 4'h0) $display("FAIL reset_mid_pre: Row=%b, required %b", Row, m_row);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (Row !== 4'h0) $display("FAIL reset_mid_row: Row=%b, required 0000", Row);
    else n_pass++;
    @(posedge clock);
    #1 reset = 1'b0;
    m_reset();
    n_checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || key_ready !== 1'b1)
      $display("FAIL reset_mid_state: count=%0d busy=%b ready=%b, required 0 0 1",
               fifo_count, busy, key_ready);
    else n_pass++;
    for (int i = 0; i < LEN + 10; i++) begin
      tick(1'b0, 4'h0, 4'hF);
      if (press_done === 1'b1 || Row !== 4'h0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL reset_mid_quiet: %0d active cycles, required 0", done_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    logic [3:0] col;
    for (int i = 0; i < 1500; i++) begin
      col = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      tick($urandom_range(0, 7) == 0, 4'($urandom), col);
      if (Row !== m_row || S_Row !== m_srow || busy !== m_busy || press_done !== m_done ||
          key_ready !== m_ready || fifo_count !== m_count) begin
        errs++;
        if (errs < 4)
          $display("FAIL random_cycle%0d: Row=%b S=%b busy=%b done=%b rdy=%b cnt=%0d, required %b %b %b %b %b %0d",
                   i, Row, S_Row, busy, press_done, key_ready, fifo_count,
                   m_row, m_srow, m_busy, m_done, m_ready, m_count);
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL random_model: %0d cycles differ, required 0", errs);
    else n_pass++;
    drain(4'hF);
  endtask

  initial begin
    test_reset();
    test_empty_push();
    test_single_press();
    test_col_patterns();
    test_back_to_back();
`ifdef HEX_KEYPAD_EMU_BOUNCE_EN
    test_bounce();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_keypad_emulator.md
Name: hex_keypad_emulator

Overview:
- Behavioural-synthesizable model of a 4x4 hex keypad: the responder on the Row/Col matrix driven by the keypad scanner.
- Accepts queued key-press requests (code 0-F) over a valid/ready handshake and "presses" each key for a programmable time.
- While a key is pressed, drives Row in response to the scanner's Col strobes, and drives a synchronized any-row flag S_Row.
- Used in board-less bring-up and as the stimulus source in scanner regression.

Parameters:
- HOLD_CYCLES, 64: cycles the contact is held closed (>=1).
- GAP_CYCLES, 16: released cycles after each press before the next request is serviced (>=1).
- BOUNCE_CYCLES, 8: bounce length at press and at release (>=1; used only with the optional feature).
- FIFO_DEPTH, 4: request queue depth (power of two, >=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared.
- key_code  in  4  requested key; Row index = key_code[3:2], Col index = key_code[1:0].
- key_valid  in  1  request present.
- key_ready  out  1  queue can accept (= queue not full).
- Col  in  4  column strobes from the scanner (any pattern, including 4'hF).
- Row  out  4  row return lines, combinational from Col, active key and contact.
- S_Row  out  1  OR of Row, synchronized through two flops.
- busy  out  1  FSM not IDLE or queue not empty.
- press_done  out  1  one-cycle pulse when a press sequence finishes (last GAP cycle).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

Behaviour:
- Reset values: Row=0 (contact=0), S_Row=0, key_ready=1, busy=0, press_done=0, fifo_count=0, FSM=IDLE, active key=0, all counters 0.
- Push: key_code enters the queue on a rising edge with key_valid && key_ready. key_valid while full is ignored; there is no overflow.
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE: if queue non-empty at the clock edge, pop the head into the active-key register. Next state is BOUNCE_IN (feature on) or HOLD (feature off). Counter loads 0.
- A push and a pop in the same cycle are both honoured; count stays unchanged. A push into an empty queue cannot be popped in the same cycle.
- BOUNCE_IN: contact = 1 on the first cycle, then toggles every cycle, for BOUNCE_CYCLES cycles. Then HOLD.
- HOLD: contact = 1 for exactly HOLD_CYCLES cycles. Then BOUNCE_OUT (feature on) or GAP (feature off).
- BOUNCE_OUT: contact = 0 on the first cycle, then toggles every cycle, for BOUNCE_CYCLES cycles. Then GAP.
- GAP: contact = 0 for GAP_CYCLES cycles. press_done=1 on the last GAP cycle. Then IDLE.
- Contact is a registered signal.
- Row = contact && Col[active[1:0]] ? (4'b0001 << active[3:2]) : 4'b0000. Row is combinational in Col so that a scanner strobe sees its row return in the same cycle.
- Multiple asserted Col bits are allowed: Row follows the active key's column bit only.
- S_Row: sync1 <= |Row; S_Row <= sync1. A rise in |Row appears on S_Row 2 edges later.
- Counters are wide enough for max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES). Terminal compare is at value-1; no wrap occurs.
- Reset mid-press: Row drops to 0 immediately (async), the queue is flushed, and the FSM returns to IDLE.

Optional Feature:
- Macro: HEX_KEYPAD_EMU_BOUNCE_EN.
- Defined: the BOUNCE_IN/BOUNCE_OUT states and their counter are built. Each press takes BOUNCE_CYCLES+HOLD_CYCLES+BOUNCE_CYCLES+GAP_CYCLES cycles after the pop.
- Undefined: the bounce states, logic and BOUNCE_CYCLES use are removed; IDLE->HOLD->GAP->IDLE. Each press takes HOLD_CYCLES+GAP_CYCLES cycles.

Test Plan:
- Feature off, push 0x6, Col held 4'b0100 -> Row=4'b0010 for exactly 64 cycles after the pop. S_Row high 2 cycles after Row rises and falls 2 cycles after Row falls. press_done pulses 80 cycles after the pop.
- Feature off, 0x6 pressed, Col stepped 0001/0010/0100/1000/1111 -> Row=0000,0000,0010,0000,0010. Same for 0xF with Col=1000 -> Row=1000; 0x0 with Col=0001 -> Row=0001.
- Push 5 codes back-to-back with FIFO_DEPTH=4 and the FSM busy -> key_ready=0 once fifo_count=4; 5th accepted only after a pop. Presses emerge in push order 0x1,0x4,0x9,0xA,0xC.
- Feature on, BOUNCE_CYCLES=8, Col=1111, key 0x3 -> Row[0] sequence 1,0,1,0,1,0,1,0, then 64 cycles of 1, then 0,1,0,1,0,1,0,1, then 16 cycles of 0.
- Assert reset during HOLD with 2 requests queued -> Row=0 same cycle; after release fifo_count=0, busy=0, key_ready=1, no press_done.
- Push into an empty idle queue -> busy=1 on the next edge; contact rises the edge after the pop.
